mantissa_mul_pipe: RTL and testbench
====================================

Name: mantissa_mul_pipe

Overview:
- Parametrised, pipelined successor to the fixed 28x28 mantissa Wallace-tree multiplier.
- Multiplies unsigned mantissas of width W in one of three SIMD partitions: 1 lane of W, 2 lanes of W/2, or 4 lanes of W/4.
- Has a valid/ready handshake, a configurable number of pipeline stages, a sideband tag and flush.
- Sits between posit decode and the FMA normalise/round stage.

Parameters:
- W, 28, operand width; must be a multiple of 4 and at least 8.
- STAGES, 2, pipeline register stages from input acceptance to output (1..4).
- TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous drop of all in-flight operations
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  W  multiplicand (lane-packed)
- in_b  in  W  multiplier (lane-packed)
- in_op  in  2  0: 1xW, 1: 2x(W/2), 2: 4x(W/4), 3: reserved
- in_tag  in  TAG_W  sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_prod  out  2W  lane-packed products
- out_op  out  2  op of this result
- out_tag  out  TAG_W  tag of this result
- out_err  out  1  result came from reserved op

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values: all stage valid bits clear; out_valid=0, out_prod=0, out_op=0, out_tag=0, out_err=0. in_ready is combinational and equals 1 after reset.
- Reset mid-operation discards every in-flight beat; no output is produced for them.
- Pipeline: linear STAGES-deep register chain, each stage holding valid, op, tag, err and partial data.
- Global advance is adv = !out_valid || out_ready. All stages shift together when adv=1 and hold otherwise.
- in_ready = adv. A beat is accepted when in_valid && in_ready.
- Latency: an accepted beat appears on out_valid exactly STAGES cycles later if adv stays 1.
- Throughput: one result per cycle.
- out_* stay stable while out_valid && !out_ready.
- Bubbles (stage valid=0) advance like data. out_prod of an invalid stage is don't-care, but the register resets to 0.
- Flush: on the cycle flush=1, all stage valid bits clear next cycle. A beat offered in the same cycle is dropped; in_ready stays at its adv value.
- Precedence: rst over flush, flush over accept.
- Lane packing, mode 0: out_prod = in_a*in_b, full 2W bits, exact.
- Lane packing, mode 1: lane k (k=0,1) operands are bits [(k+1)W/2-1 : kW/2]. The W-bit product goes to out_prod[(k+1)W-1 : kW].
- Lane packing, mode 2: lane k (k=0..3) operands are bits [(k+1)W/4-1 : kW/4]. The W/2-bit product goes to out_prod[(k+1)W/2-1 : kW/2].
- Lanes are fully isolated: no carry crosses a lane boundary in any mode.
- Implementation: a 4x4 grid of (W/4)x(W/4) partial products, masked per mode (mode 1 keeps only the diagonal quadrants, mode 2 keeps only the diagonal sub-products), then a carry-save reduction split across the stages, with a final carry-propagate adder in the last stage.
- op=3: out_prod=0 and out_err=1, with normal latency and handshake.
- All arithmetic is unsigned. The zero operand gives a zero product, and the maximum operand squared must be exact.
- op and tag travel with their data, so mixed-mode back-to-back beats are legal.

Test Plan:
- W=28, STAGES=2, op=0, a=b=0xFFFFFFF, out_ready=1 -> 2 cycles later out_valid=1, out_prod=0xFFFFFFE0000001, out_err=0.
- op=1, a=0xFFFFFFF, b=0xFFFC002 -> out_prod=0xFFF80010007FFE (lane1=0xFFF8001, lane0=0x0007FFE).
- op=2, all a lanes 0x7F, b lanes (3..0)=0x7F,0x01,0x00,0x02 -> 14-bit fields (3..0)=0x3F01,0x007F,0x0000,0x00FE.
- Stream 6 beats of mixed op with tags 0..5; hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the hold, out_* held stable, all 6 results in order with correct tags, none lost or duplicated.
- Load 2 beats, assert flush with in_valid=1 the same cycle -> no out_valid for any of the 3 beats; the next beat is accepted and completes after STAGES cycles.
- op=3, any operands -> out_prod=0, out_err=1.
- Assert rst with a full pipeline -> next cycle out_valid=0 and out_prod=0.

Source files
------------

// File: rtl/mantissa_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mantissa_mul_pipe
// Description : Pipelined, partitionable unsigned mantissa multiplier.
//               Multiplies W-bit operands as 1 lane of W, 2 lanes of W/2 or
//               4 lanes of W/4 bits. It uses a 4x4 grid of (W/4)x(W/4)
//               partial products, masked per mode, and reduces them with
//               carry-save adders spread over STAGES register stages. A
//               carry-propagate adder sits in front of the output register.
//               op, tag and the reserved-op error flag travel alongside the
//               data. A single global advance signal stalls the whole chain.
//
// Parameters  : W      operand width (multiple of 4, >= 8)
//               STAGES register stages from acceptance to output (1..4)
//               TAG_W  sideband tag width
//
// Ports       : clk, rst       clock, synchronous active-high reset
//               flush          drop every in-flight operation
//               in_valid/ready input handshake (in_ready = advance)
//               in_a, in_b     lane-packed operands
//               in_op          0: 1xW, 1: 2x(W/2), 2: 4x(W/4), 3: reserved
//               in_tag         sideband returned with the result
//               out_valid/ready output handshake
//               out_prod       lane-packed products (2W bits)
//               out_op/out_tag op and tag of the presented result
//               out_err        result came from the reserved op
//
// Revision    : 1.0  initial parametrised pipelined release
// ============================================================================
module mantissa_mul_pipe #(
    parameter int W      = 28,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_prod,
    output logic [1:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam int c_Q = W / 4;     // sub-operand width of one grid cell
    localparam int c_P = 2 * W;     // product / reduction vector width

    localparam logic [1:0] c_OP_FULL = 2'd0;
    localparam logic [1:0] c_OP_HALF = 2'd1;
    localparam logic [1:0] c_OP_QUAD = 2'd2;
    localparam logic [1:0] c_OP_RSVD = 2'd3;

    typedef logic [3:0][c_P-1:0] vec4_t;
    typedef logic [1:0][c_P-1:0] vec2_t;

    // ------------------------------------------------------------------------
    // Carry-save helpers. All vectors are c_P bits wide and carries out of the
    // top bit are dropped: the true sum always fits in c_P bits, so the
    // modular result is exact.
    // ------------------------------------------------------------------------
    function automatic logic [c_P-1:0] f_maj(input logic [c_P-1:0] x,
                                             input logic [c_P-1:0] y,
                                             input logic [c_P-1:0] z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    // 3:2 compression of vectors 0..2; vector 3 passes through untouched.
    function automatic vec4_t f_csa32(input vec4_t v);
        vec4_t r;
        r[0] = v[0] ^ v[1] ^ v[2];
        r[1] = f_maj(v[0], v[1], v[2]) << 1;
        r[2] = v[3];
        r[3] = '0;
        return r;
    endfunction

    // 4:2 compression built from two chained 3:2 levels.
    function automatic vec2_t f_csa42(input vec4_t v);
        logic [c_P-1:0] s1;
        logic [c_P-1:0] c1;
        vec2_t          r;
        s1   = v[0] ^ v[1] ^ v[2];
        c1   = f_maj(v[0], v[1], v[2]) << 1;
        r[0] = s1 ^ c1 ^ v[3];
        r[1] = f_maj(s1, c1, v[3]) << 1;
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Handshake and pipeline control
    // ------------------------------------------------------------------------
    logic             r_valid [STAGES];
    logic [1:0]       r_op    [STAGES];
    logic [TAG_W-1:0] r_tag   [STAGES];
    logic             r_err   [STAGES];
    logic             w_adv;

    // The whole chain moves as one; it only stalls when the output register
    // holds a result that downstream refuses.
    assign w_adv    = !r_valid[STAGES-1] || out_ready;
    assign in_ready = w_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                r_valid[s] <= 1'b0;
                r_op[s]    <= '0;
                r_tag[s]   <= '0;
                r_err[s]   <= 1'b0;
            end
        end else begin
            if (w_adv) begin
                r_op[0]  <= in_op;
                r_tag[0] <= in_tag;
                r_err[0] <= (in_op == c_OP_RSVD);
                for (int s = 1; s < STAGES; s++) begin
                    r_op[s]  <= r_op[s-1];
                    r_tag[s] <= r_tag[s-1];
                    r_err[s] <= r_err[s-1];
                end
            end
            // Flush clears every valid bit even while stalled, and wins over
            // a beat offered in the same cycle.
            if (flush) begin
                for (int s = 0; s < STAGES; s++) begin
                    r_valid[s] <= 1'b0;
                end
            end else if (w_adv) begin
                r_valid[0] <= in_valid;
                for (int s = 1; s < STAGES; s++) begin
                    r_valid[s] <= r_valid[s-1];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Partial-product grid. Cell (i,j) is a_i * b_j with weight 2^((i+j)Q).
    // Mode masks keep only the cells that belong to a single lane, so lanes
    // can never interact:
    //   full : all 16 cells
    //   half : cells whose operands lie in the same W/2 half (i/2 == j/2)
    //   quad : diagonal cells only (i == j)
    //   rsvd : no cells, product is zero
    // ------------------------------------------------------------------------
    logic [c_P-1:0] w_term [16];

    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        for (genvar gj = 0; gj < 4; gj++) begin : g_col
            localparam bit c_SAME_HALF = ((gi / 2) == (gj / 2));
            localparam bit c_DIAG      = (gi == gj);

            logic [2*c_Q-1:0] w_pp;
            logic             w_keep;

            assign w_pp   = {{c_Q{1'b0}}, in_a[gi*c_Q +: c_Q]}
                          * {{c_Q{1'b0}}, in_b[gj*c_Q +: c_Q]};
            assign w_keep = (in_op == c_OP_FULL)
                         || ((in_op == c_OP_HALF) && c_SAME_HALF)
                         || ((in_op == c_OP_QUAD) && c_DIAG);
            assign w_term[gi*4+gj] = w_keep
                ? ({{(c_P-2*c_Q){1'b0}}, w_pp} << ((gi + gj) * c_Q))
                : '0;
        end
    end

    // ------------------------------------------------------------------------
    // First reduction, ahead of the first register: 16 -> 8 -> 4 vectors.
    // ------------------------------------------------------------------------
    vec2_t w_lvl1 [4];
    vec2_t w_lvl2 [2];
    vec4_t w_row;

    for (genvar gk = 0; gk < 4; gk++) begin : g_lvl1
        assign w_lvl1[gk] = f_csa42({w_term[4*gk+3], w_term[4*gk+2],
                                     w_term[4*gk+1], w_term[4*gk]});
    end

    for (genvar gk = 0; gk < 2; gk++) begin : g_lvl2
        assign w_lvl2[gk] = f_csa42({w_lvl1[2*gk+1], w_lvl1[2*gk]});
    end

    assign w_row = {w_lvl2[1], w_lvl2[0]};

    // ------------------------------------------------------------------------
    // Intermediate stages carry four carry-save vectors. Stage 0 captures the
    // grid reduction; every later intermediate stage absorbs one further 3:2
    // level, so deeper pipelines leave less work for the final stage.
    // ------------------------------------------------------------------------
    vec4_t w_last_src;

    if (STAGES > 1) begin : g_mid
        vec4_t r_vec [STAGES-1];
        vec4_t w_nxt [STAGES-1];

        for (genvar gm = 0; gm < STAGES - 1; gm++) begin : g_bnd
            if (gm == 0) begin : g_first
                assign w_nxt[gm] = w_row;
            end else begin : g_fold
                assign w_nxt[gm] = f_csa32(r_vec[gm-1]);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int m = 0; m < STAGES - 1; m++) begin
                    r_vec[m] <= '0;
                end
            end else if (w_adv) begin
                for (int m = 0; m < STAGES - 1; m++) begin
                    r_vec[m] <= w_nxt[m];
                end
            end
        end

        assign w_last_src = r_vec[STAGES-2];
    end else begin : g_single
        assign w_last_src = w_row;
    end

    // ------------------------------------------------------------------------
    // Final stage: close out the carry-save form, then one carry-propagate
    // add into the output register.
    // ------------------------------------------------------------------------
    vec2_t          w_fin;
    logic [c_P-1:0] w_prod;
    logic [c_P-1:0] r_prod;

    assign w_fin  = f_csa42(w_last_src);
    assign w_prod = w_fin[0] + w_fin[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod <= '0;
        end else if (w_adv) begin
            r_prod <= w_prod;
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_prod  = r_prod;
    assign out_op    = r_op[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign out_err   = r_err[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_mantissa_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mantissa_mul_pipe
// Description : Self-checking scoreboard bench for mantissa_mul_pipe
//               (W=28, STAGES=2, TAG_W=4). Expected results are pushed when
//               a beat is accepted and compared when the DUT presents output.
// Revision    : 1.0  initial bench
// ============================================================================
module tb_mantissa_mul_pipe;

    localparam int W      = 28;
    localparam int STAGES = 2;
    localparam int TAG_W  = 4;

    logic             clk;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   out_prod;
    logic [1:0]       out_op;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    mantissa_mul_pipe #(
        .W      (W),
        .STAGES (STAGES),
        .TAG_W  (TAG_W)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_op    (out_op),
        .out_tag   (out_tag),
        .out_err   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2*W-1:0]   prod;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic             err;
        int               acc;
        bit               lat;
    } item_t;

    item_t sb[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference lane model, written lane by lane.
    function automatic logic [2*W-1:0] model(input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [1:0]   op);
        logic [2*W-1:0] r;
        logic [W/2-1:0] ha, hb;
        logic [W/4-1:0] qa, qb;
        r = '0;
        case (op)
            2'd0: r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            2'd1: begin
                for (int k = 0; k < 2; k++) begin
                    ha = a[k*(W/2) +: W/2];
                    hb = b[k*(W/2) +: W/2];
                    r[k*W +: W] = {{(W/2){1'b0}}, ha} * {{(W/2){1'b0}}, hb};
                end
            end
            2'd2: begin
                for (int k = 0; k < 4; k++) begin
                    qa = a[k*(W/4) +: W/4];
                    qb = b[k*(W/4) +: W/4];
                    r[k*(W/2) +: W/2] = {{(W/4){1'b0}}, qa} * {{(W/4){1'b0}}, qb};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Output monitor: compares against the scoreboard head every cycle the
    // output is valid (so a stalled result is re-checked each cycle), pops on
    // handshake.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                chk("prod", 64'(out_prod), 64'(sb[0].prod));
                chk("op",   64'(out_op),   64'(sb[0].op));
                chk("tag",  64'(out_tag),  64'(sb[0].tag));
                chk("err",  64'(out_err),  64'(sb[0].err));
                if (sb[0].lat)
                    chk("latency", 64'(cyc - sb[0].acc), 64'(STAGES));
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    // Drives one beat and waits (bounded) for acceptance. Called and returns
    // one time unit after a rising edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input logic [2*W-1:0] exp, input bit lat);
        item_t it;
        bit    done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        in_tag   = tag;
        for (int t = 0; t < 60 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                it.prod = exp;
                it.op   = op;
                it.tag  = tag;
                it.err  = (op == 2'd3);
                it.acc  = cyc;
                it.lat  = lat;
                sb.push_back(it);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] tag, input logic [1:0] op);
        logic [W-1:0] a, b;
        a = W'($urandom());
        b = W'($urandom());
        send(a, b, op, tag, model(a, b, op), 1'b0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_prod",  64'(out_prod),  64'd0);
        chk("rst_out_op",    64'(out_op),    64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_out_err",   64'(out_err),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // Directed back-to-back beats, mixed modes, latency checked
        send(28'hFFFFFFF, 28'hFFFFFFF, 2'd0, 4'd1, 56'hFFFFFFE0000001, 1'b1);
        send(28'hFFFFFFF, 28'hFFFC002, 2'd1, 4'd2, 56'hFFF80010007FFE, 1'b1);
        send(28'hFFFFFFF, 28'hFE04002, 2'd2, 4'd3,
             (56'h3F01 << 42) | (56'h007F << 28) | 56'h00FE, 1'b1);
        send(28'h1234567, 28'h7654321, 2'd3, 4'd4, 56'd0, 1'b1);
        send(28'h0000000, 28'hFFFFFFF, 2'd0, 4'd5, 56'd0, 1'b1);
        send(28'hFFFFFFF, 28'hFFFFFFF, 2'd2, 4'd6, model(28'hFFFFFFF, 28'hFFFFFFF, 2'd2), 1'b1);
        idle();
        drain();

        // Six-beat mixed stream with a three-cycle output stall mid-stream
        fork
            begin
                for (int i = 0; i < 6; i++) send_rand(TAG_W'(i), 2'(i % 4));
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("hold_in_ready", 64'(in_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Longer random stream with random backpressure
        fork
            begin
                for (int i = 0; i < 30; i++) send_rand(TAG_W'(i), 2'($urandom_range(0, 3)));
                idle();
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Flush: one beat in flight, a second offered with flush, then a
        // fresh beat that must complete normally.
        in_valid = 1'b1;
        in_a     = 28'h0ABCDEF;
        in_b     = 28'h0123456;
        in_op    = 2'd0;
        in_tag   = 4'd9;
        @(posedge clk);
        #1;
        flush  = 1'b1;
        in_a   = 28'h0FEDCBA;
        in_tag = 4'd10;
        @(negedge clk);
        chk("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        send(28'h0000123, 28'h0000456, 2'd0, 4'd11, 56'h0000000004EDC2, 1'b1);
        idle();
        drain();

        // Reset with a full pipeline
        send(28'h1111111, 28'h2222222, 2'd0, 4'd12, model(28'h1111111, 28'h2222222, 2'd0), 1'b0);
        send(28'h3333333, 28'h4444444, 2'd0, 4'd13, model(28'h3333333, 28'h4444444, 2'd0), 1'b0);
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_prod",  64'(out_prod),  64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (STAGES + 3) @(posedge clk);
        #1;
        send(28'h0000007, 28'h0000009, 2'd0, 4'd14, 56'd63, 1'b1);
        idle();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
